// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with per-frame snapshot.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] number,
  input  logic        display_lines,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_LINES = 7'b0111111;

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          first_q;
  logic [15:0]   snap_number_q;
  logic          snap_lines_q;
  logic [3:0]    snap_dp_mask_q;

  logic          cnt_wrap;
  logic          snap_en;
  logic          slot_blank;
  logic          digit_en;
  logic [3:0]    nibble;
  logic [3:0]    digit_keep;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign cnt_wrap   = (cnt_q == CNT_LAST);
  // first_q forces a snapshot on the first edge after reset so the display never shows stale zeros.
  assign snap_en    = first_q || (cnt_wrap && (idx_q == 2'd3));
  assign slot_blank = (cnt_q < CNT_BLANK);

  always_comb begin
    nibble = snap_number_q[3:0];
    case (idx_q)
      2'd0: nibble = snap_number_q[3:0];
      2'd1: nibble = snap_number_q[7:4];
      2'd2: nibble = snap_number_q[11:8];
      default: nibble = snap_number_q[15:12];
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit stays lit if it or any more-significant nibble is non-zero.
  assign digit_keep = {|snap_number_q[15:12], |snap_number_q[15:8], |snap_number_q[15:4], 1'b1};
  assign digit_en   = snap_lines_q || digit_keep[idx_q];
`else
  assign digit_keep = 4'hF;
  assign digit_en   = digit_keep[idx_q];
`endif

  // NOTE: every register here, snapshot included, is reset so pins are defined the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      first_q        <= 1'b1;
      snap_number_q  <= '0;
      snap_lines_q   <= 1'b0;
      snap_dp_mask_q <= '0;
      an             <= 4'hF;
      seg            <= SEG_OFF;
      dp             <= 1'b1;
      frame_tick     <= 1'b0;
    end else begin
      first_q    <= 1'b0;
      frame_tick <= snap_en;
      if (snap_en) begin
        snap_number_q  <= number;
        snap_lines_q   <= display_lines;
        snap_dp_mask_q <= dp_mask;
      end

      if (cnt_wrap) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Pins follow the slot state one cycle late; the current snapshot is used throughout.
      if (slot_blank || !digit_en) begin
        an  <= 4'hF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_q);
        seg <= snap_lines_q ? SEG_LINES : hex_to_seg(nibble);
        dp  <= snap_lines_q ? 1'b1 : ~snap_dp_mask_q[idx_q];
      end
    end
  end

  param_legal: assert property (@(posedge clk) (DIV >= 2) && (BLANK_CYCLES < DIV));

endmodule
